// File: rtl/i2s_rx_slot_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_rx_slot_sequencer
//
// Receive-side sequencer of the I2S RX core. It watches the synchronized SCK
// for rising edges, tracks word-select transitions, and steps a bit index
// down through each channel word. The index and a write strobe drive the
// downstream binary-to-one-hot bit decoder. The module also assembles the
// left and right samples MSB-first and presents one stereo pair per frame
// on a valid/ready interface.
//
// Slots longer than DATA_WIDTH are truncated: the extra LSBs are ignored.
// Slots shorter than DATA_WIDTH are zero-padded at the bottom: the word is
// closed by the WS transition.
//
// Ports
//   clk_i      system clock (single domain)
//   rst_i      asynchronous active-high reset
//   en_i       sequencer enable; low returns to IDLE and drops partial data
//   sck_i      I2S bit clock (already synchronized)
//   ws_i       I2S word select, 0 = left, 1 = right (synchronized)
//   sd_i       I2S serial data (synchronized)
//   bit_idx_o  bit position being written (decoder select)
//   bit_we_o   one-cycle strobe qualifying the decoder write
//   bit_o      sampled data bit accompanying bit_we_o
//   left_o     left sample of the presented pair
//   right_o    right sample of the presented pair
//   valid_o    pair available
//   ready_i    consumer accepts the pair
//   overrun_o  one-cycle pulse when a completed pair is dropped
// ---------------------------------------------------------------------------
module i2s_rx_slot_sequencer #(
    parameter int DATA_WIDTH  = 24,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   sck_i,
    input  logic                   ws_i,
    input  logic                   sd_i,
    output logic [INDEX_WIDTH-1:0] bit_idx_o,
    output logic                   bit_we_o,
    output logic                   bit_o,
    output logic [DATA_WIDTH-1:0]  left_o,
    output logic [DATA_WIDTH-1:0]  right_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] IDX_MSB = INDEX_WIDTH'(DATA_WIDTH - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE = INDEX_WIDTH'(1);

    // Sequencer state
    state_t                  state_q, state_d;
    logic                    sck_q;
    logic                    ws_last_q, ws_last_d;
    logic                    ch_q, ch_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [DATA_WIDTH-1:0]   left_hold_q, left_hold_d;
    logic                    left_ok_q, left_ok_d;

    // Registered outputs
    logic [INDEX_WIDTH-1:0]  bit_idx_q, bit_idx_d;
    logic                    bit_we_q, bit_we_d;
    logic                    bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   left_q, left_d;
    logic [DATA_WIDTH-1:0]   right_q, right_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic                    rise;
    logic                    ws_edge;
    logic                    finalize;
    logic [DATA_WIDTH-1:0]   wr_word;

    // Writes bit_v at position idx and clears every bit below it. Bits are
    // written from the MSB down, so the cleared bits are either rewritten
    // later in the same word or, for a short slot, are exactly the
    // zero padding the finalized word needs.
    function automatic logic [DATA_WIDTH-1:0] write_bit(
        input logic [DATA_WIDTH-1:0]  word,
        input logic [INDEX_WIDTH-1:0] idx,
        input logic                   bit_v
    );
        logic [DATA_WIDTH-1:0] w;
        w = word;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == int'(idx)) begin
                w[i] = bit_v;
            end else if (i < int'(idx)) begin
                w[i] = 1'b0;
            end
        end
        return w;
    endfunction

    assign rise    = sck_i & ~sck_q;
    // The bit carried on a WS transition still belongs to the old channel.
    assign ws_edge = rise & (ws_i ^ ws_last_q);
    assign wr_word = write_bit(word_q, idx_q, sd_i);

    always_comb begin
        state_d     = state_q;
        ws_last_d   = ws_last_q;
        ch_d        = ch_q;
        idx_d       = idx_q;
        word_d      = word_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        bit_idx_d   = bit_idx_q;
        bit_we_d    = 1'b0;
        bit_d       = bit_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        finalize    = 1'b0;

        if (rise) begin
            ws_last_d = ws_i;
        end

        // A consumed pair drops valid unless a new pair is loaded below.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (!en_i) begin
            state_d   = ST_IDLE;
            word_d    = '0;
            idx_d     = '0;
            left_ok_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Only a falling WS edge marks the start of a frame.
                    if (ws_edge && !ws_i) begin
                        ch_d    = 1'b0;
                        idx_d   = IDX_MSB;
                        state_d = ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (rise) begin
                        word_d    = wr_word;
                        bit_we_d  = 1'b1;
                        bit_idx_d = idx_q;
                        bit_d     = sd_i;
                        if (ws_edge) begin
                            // Short slot: close this word, start the next one.
                            finalize = 1'b1;
                            ch_d     = ws_i;
                            idx_d    = IDX_MSB;
                        end else if (idx_q == '0) begin
                            finalize = 1'b1;
                            state_d  = ST_PAD;
                        end else begin
                            idx_d = idx_q - IDX_ONE;
                        end
                    end
                end

                ST_PAD: begin
                    if (ws_edge) begin
                        ch_d    = ws_i;
                        idx_d   = IDX_MSB;
                        state_d = ST_SHIFT;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (finalize) begin
                if (!ch_q) begin
                    left_hold_d = wr_word;
                    left_ok_d   = 1'b1;
                end else if (left_ok_q) begin
                    left_ok_d = 1'b0;
                    if (!valid_q || ready_i) begin
                        left_d  = left_hold_q;
                        right_d = wr_word;
                        valid_d = 1'b1;
                    end else begin
                        // Presented pair is still pending: drop the new one.
                        overrun_d = 1'b1;
                    end
                end
                // A right word without a preceding left word is discarded.
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sck_q       <= 1'b0;
            ws_last_q   <= 1'b0;
            ch_q        <= 1'b0;
            idx_q       <= '0;
            word_q      <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            bit_idx_q   <= '0;
            bit_we_q    <= 1'b0;
            bit_q       <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_i;
            ws_last_q   <= ws_last_d;
            ch_q        <= ch_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            bit_idx_q   <= bit_idx_d;
            bit_we_q    <= bit_we_d;
            bit_q       <= bit_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bit_idx_o = bit_idx_q;
    assign bit_we_o  = bit_we_q;
    assign bit_o     = bit_q;
    assign left_o    = left_q;
    assign right_o   = right_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_i2s_rx_slot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_slot_sequencer
//
// Drives I2S frames of several slot lengths into i2s_rx_slot_sequencer and
// compares the decoder strobes, the delivered stereo pairs and the overrun
// pulses against values derived from the transmitted frames.
// ---------------------------------------------------------------------------
module tb_i2s_rx_slot_sequencer;

    localparam int DW = 24;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sck;
    logic          ws;
    logic          sd;
    logic          ready;
    logic [IW-1:0] bit_idx;
    logic          bit_we;
    logic          bit_v;
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic          valid;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    // Serial stream still to be played (one entry per SCK rise).
    logic ws_s[$];
    logic sd_s[$];

    // Observed traffic.
    logic [IW-1:0]   st_idx[$];
    logic            st_bit[$];
    logic [2*DW-1:0] acc[$];
    int              ovr_cnt = 0;

    // Expected traffic.
    logic [2*DW-1:0] exp_q[$];
    int              exp_ovr = 0;

    i2s_rx_slot_sequencer #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .sck_i    (sck),
        .ws_i     (ws),
        .sd_i     (sd),
        .bit_idx_o(bit_idx),
        .bit_we_o (bit_we),
        .bit_o    (bit_v),
        .left_o   (left),
        .right_o  (right),
        .valid_o  (valid),
        .ready_i  (ready),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: samples just after the inactive edge.
    logic            prev_valid = 1'b0;
    logic            hold       = 1'b0;
    logic [2*DW-1:0] held       = '0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
            hold       = 1'b0;
        end else begin
            if (bit_we) begin
                st_idx.push_back(bit_idx);
                st_bit.push_back(bit_v);
            end
            if (overrun) begin
                ovr_cnt++;
                check("ovr_with_final_strobe", 64'(bit_we), 64'd1);
            end
            if (valid && !prev_valid) begin
                check("valid_with_final_strobe", 64'(bit_we), 64'd1);
            end
            if (hold) begin
                check("pair_held_stable", 64'({valid, left, right}), 64'({1'b1, held}));
            end
            if (valid && ready) begin
                acc.push_back({left, right});
            end
            hold       = valid && !ready;
            held       = {left, right};
            prev_valid = valid;
        end
    end

    // One SCK period = 4 clk: 2 low, 2 high. Called at a negedge.
    task automatic rise_bit(input logic w, input logic d);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic play_n(input int n);
        for (int i = 0; i < n && ws_s.size() > 0; i++) begin
            rise_bit(ws_s.pop_front(), sd_s.pop_front());
        end
    endtask

    task automatic play_all();
        play_n(ws_s.size());
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #2;
        @(negedge clk);
    endtask

    // WS high then the 1->0 transition that opens a frame.
    task automatic preamble();
        ws_s.push_back(1'b1); sd_s.push_back(1'($urandom));
        ws_s.push_back(1'b0); sd_s.push_back(1'($urandom));
    endtask

    // I2S framing: the LSB of each channel rides on the WS change.
    task automatic build_frame(input int L, input logic [31:0] lw, input logic [31:0] rw);
        for (int b = L - 1; b >= 0; b--) begin
            ws_s.push_back(b == 0);
            sd_s.push_back(lw[b]);
        end
        for (int b = L - 1; b >= 0; b--) begin
            ws_s.push_back(b != 0);
            sd_s.push_back(rw[b]);
        end
    endtask

    function automatic logic [31:0] rand_slot(input int L);
        logic [31:0] s;
        s = $urandom;
        if (L < 32) s = s & ((32'd1 << L) - 32'd1);
        return s;
    endfunction

    // Sample value a slot of L bits maps to: MSB-aligned in DW bits.
    function automatic logic [DW-1:0] exp_word(input int L, input logic [31:0] s);
        logic [63:0] t;
        t = {32'd0, s};
        if (L >= DW) t = t >> (L - DW);
        else         t = t << (DW - L);
        return t[DW-1:0];
    endfunction

    task automatic frame_checked(input int L, input logic [31:0] lw, input logic [31:0] rw,
                                 input bit want_pair);
        int          n;
        logic [31:0] w;
        st_idx.delete();
        st_bit.delete();
        build_frame(L, lw, rw);
        play_all();
        settle();
        n = (L < DW) ? L : DW;
        check("strobe_count", 64'(st_idx.size()), 64'(2 * n));
        if (st_idx.size() == 2 * n) begin
            for (int c = 0; c < 2; c++) begin
                w = (c == 1) ? rw : lw;
                for (int k = 0; k < n; k++) begin
                    check("strobe_idx", 64'(st_idx[c * n + k]), 64'(DW - 1 - k));
                    check("strobe_bit", 64'(st_bit[c * n + k]), 64'(w[L - 1 - k]));
                end
            end
        end
        if (want_pair) exp_q.push_back({exp_word(L, lw), exp_word(L, rw)});
    endtask

    task automatic compare_pairs(input string tag);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_pair_count"}, 64'(acc.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc.size(); i++) begin
            check({tag, "_pair_data"}, 64'(acc[i]), 64'(exp_q[i]));
        end
        check({tag, "_overruns"}, 64'(ovr_cnt), 64'(exp_ovr));
        acc.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bit_idx"}, 64'(bit_idx), 64'd0);
        check({tag, "_bit_we"},  64'(bit_we),  64'd0);
        check({tag, "_bit"},     64'(bit_v),   64'd0);
        check({tag, "_left"},    64'(left),    64'd0);
        check({tag, "_right"},   64'(right),   64'd0);
        check({tag, "_valid"},   64'(valid),   64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    int          lens[5] = '{16, 20, 24, 28, 32};
    int          L;
    logic [31:0] a;
    logic [31:0] b;

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        sck   = 1'b0;
        ws    = 1'b0;
        sd    = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);

        // 32-bit slots, fixed pattern, then random 32-bit frames.
        preamble();
        play_all();
        frame_checked(32, {24'hA5A5A5, 8'($urandom)}, {24'h5A5A5A, 8'($urandom)}, 1'b0);
        exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        for (int i = 0; i < 3; i++) frame_checked(32, rand_slot(32), rand_slot(32), 1'b1);
        compare_pairs("slot32");

        // 16-bit slots zero-padded, then random slot lengths.
        frame_checked(16, 32'h1234, 32'hBEEF, 1'b0);
        exp_q.push_back({24'h123400, 24'hBEEF00});
        for (int i = 0; i < 6; i++) begin
            L = lens[$urandom_range(0, 4)];
            frame_checked(L, rand_slot(L), rand_slot(L), 1'b1);
        end
        compare_pairs("mixed");

        // Consumer stalled for two frames: first pair held, second dropped.
        ready = 1'b0;
        a = rand_slot(24) | 32'h80_0000;
        b = rand_slot(24);
        frame_checked(24, a, b, 1'b0);
        exp_q.push_back({exp_word(24, a), exp_word(24, b)});
        frame_checked(24, rand_slot(24), rand_slot(24), 1'b0);
        exp_ovr++;
        check("stall_valid", 64'(valid), 64'd1);
        check("stall_left", 64'(left), 64'(exp_word(24, a)));
        compare_pairs("stall");

        // Start while WS is high mid right word.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ws_s.push_back(1'b1);
            sd_s.push_back(1'($urandom));
        end
        ws_s.push_back(1'b0);
        sd_s.push_back(1'($urandom));
        play_all();
        settle();
        check("ws1_no_valid", 64'(valid), 64'd0);
        frame_checked(24, rand_slot(24), rand_slot(24), 1'b1);
        compare_pairs("ws1_start");

        // Asynchronous reset in the middle of a left word with a pair pending.
        ready = 1'b0;
        frame_checked(24, rand_slot(24) | 32'h80_0000, rand_slot(24), 1'b0);
        build_frame(24, rand_slot(24), rand_slot(24));
        play_n(10);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ws_s.delete();
        sd_s.delete();
        ready = 1'b1;
        preamble();
        play_all();
        frame_checked(32, rand_slot(32), rand_slot(32), 1'b1);
        compare_pairs("after_reset");

        // Enable dropped mid left word: that frame must yield nothing.
        build_frame(28, rand_slot(28), rand_slot(28));
        play_n(10);
        en = 1'b0;
        play_n(5);
        en = 1'b1;
        play_all();
        settle();
        check("en_drop_no_pair", 64'(acc.size()), 64'd0);
        check("en_drop_no_valid", 64'(valid), 64'd0);
        frame_checked(20, rand_slot(20), rand_slot(20), 1'b1);
        compare_pairs("en_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/i2s_rx_slot_sequencer.md
# i2s_rx_slot_sequencer

Sequences the I2S receive datapath. It tracks SCK edges and WS transitions, and steps a bit index through each channel word; that index drives the binary-to-one-hot bit decoder. It assembles left and right samples MSB-first and hands out one stereo pair per frame on a valid/ready interface. It sits between the pin synchronizers and the sample FIFO of the I2S RX core.

## Interface
- DATA_WIDTH, 24, sample width in bits (8..32)
- INDEX_WIDTH, 5, bit index width; 2**INDEX_WIDTH >= DATA_WIDTH
- clk_i  input  1  system clock, single clock domain
- rst_i  input  1  asynchronous, active-high reset
- en_i  input  1  sequencer enable; low forces IDLE synchronously
- sck_i  input  1  I2S bit clock, already synchronized to clk_i
- ws_i  input  1  I2S word select (0 = left, 1 = right), synchronized
- sd_i  input  1  I2S serial data, synchronized
- bit_idx_o  output  INDEX_WIDTH  bit position being written; feeds the decoder select
- bit_we_o  output  1  one-cycle strobe qualifying the decoder one-hot write
- bit_o  output  1  sampled data bit accompanying bit_we_o
- left_o  output  DATA_WIDTH  left sample of the presented pair
- right_o  output  DATA_WIDTH  right sample of the presented pair
- valid_o  output  1  pair available
- ready_i  input  1  consumer accepts the pair
- overrun_o  output  1  one-cycle pulse when a completed pair is dropped

## Operation
- SCK rise detection: sck_d is a registered copy of sck_i. rise = sck_i & ~sck_d. ws_i and sd_i are sampled in the rise cycle only.
- ws_last is updated on every rise. A transition is a rise where ws_i != ws_last. The bit on a transition rise belongs to the previous channel, and the next rise carries the MSB of the new channel.
- States:
  - IDLE: default after reset or !en_i. A transition with ws_i == 0 sets ch = 0, idx = DATA_WIDTH-1 and moves to SHIFT. A transition to 1 is ignored.
  - SHIFT: each non-transition rise writes sd_i into word[idx] and strobes bit_we_o with bit_idx_o = idx. If idx == 0, the word is finalized and the state moves to PAD; otherwise idx decrements. On a transition rise (short slot), sd_i is written at idx, lower bits are forced to 0, and the word is finalized. The sequencer then re-enters SHIFT for the new channel with ch = ws_i and idx = DATA_WIDTH-1.
  - PAD: non-transition rises are ignored. A transition rise re-enters SHIFT with ch = ws_i and idx = DATA_WIDTH-1.
- Finalize left: load left_hold and set left_ok.
- Finalize right with left_ok set: if !valid_o or ready_i, load left_o/right_o and set valid_o. Otherwise keep the presented pair and pulse overrun_o. Clear left_ok in both cases.
- Finalize right with left_ok clear: discard the word; no overrun.
- Handshake: left_o/right_o are stable while valid_o && !ready_i. valid_o && ready_i drops valid_o next cycle unless a new pair loads in the same cycle, in which case valid_o stays high with the new data.
- en_i low: go to IDLE, clear the partial word, idx and left_ok. A pending pair stays until it is accepted.
- rst_i: asynchronous clear of all state.

## Timing
- Reset values:
  - State IDLE; ws_last 0, sck_d 0.
  - bit_idx_o 0, bit_we_o 0, bit_o 0.
  - left_o 0, right_o 0, valid_o 0, overrun_o 0.
- clk_i frequency >= 4x SCK, so every rise is seen as one distinct cycle.
- bit_we_o, bit_idx_o and bit_o are registered and assert 1 clk after the rise cycle.
- valid_o asserts 1 clk after the rise carrying the right-channel LSB, or after the terminating transition for a short slot. overrun_o pulses in that same cycle.
- First pair after reset or enable requires a full 1->0 WS transition followed by a complete left word and a complete right word.

## Test plan
- 32-bit slots, DATA_WIDTH 24, left 0xA5A5A5, right 0x5A5A5A, ready_i high -> valid_o with left_o=0xA5A5A5, right_o=0x5A5A5A, 1 clk after right bit 0. bit_we_o pulses exactly 48 times per frame, with bit_idx_o running 23..0 per channel.
- 16-bit slots, left 0x1234, right 0xBEEF -> left_o=0x123400, right_o=0xBEEF00.
- ready_i low for two full frames -> first pair held stable. One overrun_o pulse at the second frame's right finalize. The first pair is delivered when ready_i rises.
- Start with ws_i=1 mid-right-word after reset -> no valid_o until the following 1->0 transition plus one full frame.
- rst_i asserted mid-SHIFT -> all outputs 0 asynchronously. The next frame decodes correctly.
- en_i dropped mid-left word and reasserted -> partial data discarded; first valid pair comes from the next complete frame.
